// File: rtl/evolve_ctrl.sv
// rtl/evolve_ctrl.sv - XP/level engine and start/done evolution animation initiator (optional cancel: EVOLVE_CANCEL_EN)
module evolve_ctrl #(
    parameter int LEVEL_XP    = 100,
    parameter int EVOLVE_LVL1 = 16,
    parameter int EVOLVE_LVL2 = 36,
    parameter int MAX_LEVEL   = 100
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic       xp_valid_in,
    input  logic [7:0] xp_in,
    input  logic [7:0] base_sprite_in,
    input  logic       done_in,
    input  logic       cancel_in,
    output logic       start_out,
    output logic [7:0] sprite_out,
    output logic [6:0] level_out,
    output logic [1:0] stage_out,
    output logic       busy_out,
    output logic       evolved_out,
    output logic       cancelled_out
);

    localparam logic [15:0] XP_STEP  = 16'(LEVEL_XP);
    localparam logic [6:0]  LVL1     = 7'(EVOLVE_LVL1);
    localparam logic [6:0]  LVL2     = 7'(EVOLVE_LVL2);
    localparam logic [6:0]  LVL_MAX  = 7'(MAX_LEVEL);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_REQ,
        S_COMMIT,
        S_ABORT
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] xp_bank;
    logic [15:0] bank_nxt;
    logic [17:0] bank_sum;
    logic        declined;
    logic        cancel_req;
    logic        due;
    logic        level_up;
    logic        commit_go;
    logic [1:0]  stage_inc;

`ifdef EVOLVE_CANCEL_EN
    assign cancel_req = cancel_in;
`else
    logic unused_cancel;
    assign unused_cancel = cancel_in;
    assign cancel_req    = 1'b0;
    assign declined      = 1'b0;
    assign cancelled_out = 1'b0;
`endif

    // Trigger check outranks the level-up engine in the same IDLE cycle.
    assign due = (state == S_IDLE) && !declined &&
                 (((stage_out == 2'd0) && (level_out >= LVL1)) ||
                  ((stage_out == 2'd1) && (level_out >= LVL2)));

    assign level_up = (state == S_IDLE) && !due &&
                      (xp_bank >= XP_STEP) && (level_out < LVL_MAX);

    // Level-up only fires with bank >= step, so the sum never goes negative.
    assign bank_sum = {2'b00, xp_bank}
                    + (xp_valid_in ? {10'd0, xp_in} : 18'd0)
                    - (level_up ? {2'b00, XP_STEP} : 18'd0);
    assign bank_nxt = (bank_sum[17:16] != 2'b00) ? 16'hFFFF : bank_sum[15:0];

    assign commit_go = (state == S_REQ) && (state_nxt == S_COMMIT);
    assign stage_inc = (stage_out == 2'd2) ? 2'd2 : stage_out + 2'd1;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (due) state_nxt = S_ARM;
            S_ARM:    if (!done_in) state_nxt = S_REQ;
            S_REQ: begin
                if (done_in)         state_nxt = S_COMMIT;
                else if (cancel_req) state_nxt = S_ABORT;
            end
            S_COMMIT: state_nxt = S_IDLE;
            S_ABORT:  state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state       <= S_IDLE;
            xp_bank     <= 16'd0;
            level_out   <= 7'd1;
            stage_out   <= 2'd0;
            sprite_out  <= 8'd0;
            start_out   <= 1'b0;
            busy_out    <= 1'b0;
            evolved_out <= 1'b0;
        end else begin
            state       <= state_nxt;
            xp_bank     <= bank_nxt;
            start_out   <= (state_nxt == S_ARM) || (state_nxt == S_REQ);
            busy_out    <= (state_nxt != S_IDLE);
            evolved_out <= commit_go;
            if (level_up)
                level_out <= level_out + 7'd1;
            if (commit_go) begin
                stage_out  <= stage_inc;
                sprite_out <= base_sprite_in + {6'd0, stage_inc};
            end else if (state == S_IDLE) begin
                sprite_out <= base_sprite_in + {6'd0, stage_out};
            end
        end
    end

`ifdef EVOLVE_CANCEL_EN
    // A declined evolution stays suppressed until the creature levels again.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            declined      <= 1'b0;
            cancelled_out <= 1'b0;
        end else begin
            cancelled_out <= (state == S_REQ) && (state_nxt == S_ABORT);
            if ((state == S_REQ) && (state_nxt == S_ABORT))
                declined <= 1'b1;
            else if (level_up)
                declined <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_evolve_ctrl.sv
// tb/tb_evolve_ctrl.sv - directed self-checking bench for evolve_ctrl
module tb_evolve_ctrl;

    logic       clk_in = 1'b0;
    logic       rst_n_in;
    logic       xp_valid_in;
    logic [7:0] xp_in;
    logic [7:0] base_sprite_in;
    logic       done_in;
    logic       cancel_in;
    logic       start_out;
    logic [7:0] sprite_out;
    logic [6:0] level_out;
    logic [1:0] stage_out;
    logic       busy_out;
    logic       evolved_out;
    logic       cancelled_out;

    int errors = 0;
    int checks = 0;

    always #5 clk_in = ~clk_in;

    evolve_ctrl dut (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .xp_valid_in    (xp_valid_in),
        .xp_in          (xp_in),
        .base_sprite_in (base_sprite_in),
        .done_in        (done_in),
        .cancel_in      (cancel_in),
        .start_out      (start_out),
        .sprite_out     (sprite_out),
        .level_out      (level_out),
        .stage_out      (stage_out),
        .busy_out       (busy_out),
        .evolved_out    (evolved_out),
        .cancelled_out  (cancelled_out)
    );

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic strobe(input logic [7:0] amount, input int count);
        for (int i = 0; i < count; i++) begin
            xp_valid_in = 1'b1;
            xp_in       = amount;
            tick();
        end
        xp_valid_in = 1'b0;
        xp_in       = 8'd0;
    endtask

    task automatic test_reset();
        rst_n_in = 1'b0; xp_valid_in = 1'b0; xp_in = 8'd0;
        base_sprite_in = 8'h40; done_in = 1'b0; cancel_in = 1'b0;
        tick(); tick();
        checks++; if (start_out !== 1'b0) begin errors++; $display("FAIL rst_start: got %0h exp 0", start_out); end
        checks++; if (sprite_out !== 8'h00) begin errors++; $display("FAIL rst_sprite: got %0h exp 0", sprite_out); end
        checks++; if (level_out !== 7'd1) begin errors++; $display("FAIL rst_level: got %0d exp 1", level_out); end
        checks++; if (stage_out !== 2'd0) begin errors++; $display("FAIL rst_stage: got %0d exp 0", stage_out); end
        checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0h exp 0", busy_out); end
        checks++; if (evolved_out !== 1'b0) begin errors++; $display("FAIL rst_evolved: got %0h exp 0", evolved_out); end
        checks++; if (cancelled_out !== 1'b0) begin errors++; $display("FAIL rst_cancelled: got %0h exp 0", cancelled_out); end
        rst_n_in = 1'b1;
        tick();
        checks++; if (sprite_out !== 8'h40) begin errors++; $display("FAIL idle_sprite: got %0h exp 40", sprite_out); end
    endtask

    task automatic test_level_up();
        strobe(8'd200, 1);
        checks++; if (level_out !== 7'd1) begin errors++; $display("FAIL lvl_first: got %0d exp 1", level_out); end
        checks++; if (dut.xp_bank !== 16'd200) begin errors++; $display("FAIL bank_200: got %0d exp 200", dut.xp_bank); end
        tick();
        checks++; if (level_out !== 7'd2) begin errors++; $display("FAIL lvl_2: got %0d exp 2", level_out); end
        tick();
        checks++; if (level_out !== 7'd3) begin errors++; $display("FAIL lvl_3: got %0d exp 3", level_out); end
        checks++; if (dut.xp_bank !== 16'd0) begin errors++; $display("FAIL bank_0: got %0d exp 0", dut.xp_bank); end
        checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL lvl_busy: got %0h exp 0", busy_out); end
        tick();
        checks++; if (level_out !== 7'd3) begin errors++; $display("FAIL lvl_hold: got %0d exp 3", level_out); end
    endtask

    task automatic test_evolve_stage1();
        done_in = 1'b1;
        strobe(8'd100, 13);
        for (int i = 0; i < 20 && level_out != 7'd16; i++) tick();
        checks++; if (level_out !== 7'd16) begin errors++; $display("FAIL lvl_16: got %0d exp 16", level_out); end
        checks++; if (start_out !== 1'b0) begin errors++; $display("FAIL start_at_n: got %0h exp 0", start_out); end
        tick();
        checks++; if (start_out !== 1'b1) begin errors++; $display("FAIL start_n1: got %0h exp 1", start_out); end
        checks++; if (busy_out !== 1'b1) begin errors++; $display("FAIL busy_arm: got %0h exp 1", busy_out); end
        repeat (3) tick();
        checks++; if (start_out !== 1'b1) begin errors++; $display("FAIL arm_hold: got %0h exp 1", start_out); end
        checks++; if (stage_out !== 2'd0) begin errors++; $display("FAIL arm_stage: got %0d exp 0", stage_out); end
        done_in = 1'b0;
        tick();
        checks++; if (start_out !== 1'b1) begin errors++; $display("FAIL req_start: got %0h exp 1", start_out); end
        done_in = 1'b1;
        tick();
        done_in = 1'b0;
        checks++; if (evolved_out !== 1'b1) begin errors++; $display("FAIL evolved1: got %0h exp 1", evolved_out); end
        checks++; if (stage_out !== 2'd1) begin errors++; $display("FAIL stage1: got %0d exp 1", stage_out); end
        checks++; if (sprite_out !== 8'h41) begin errors++; $display("FAIL sprite1: got %0h exp 41", sprite_out); end
        checks++; if (start_out !== 1'b0) begin errors++; $display("FAIL commit_start: got %0h exp 0", start_out); end
        tick();
        checks++; if (evolved_out !== 1'b0) begin errors++; $display("FAIL evolved_pulse: got %0h exp 0", evolved_out); end
        checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL idle_busy: got %0h exp 0", busy_out); end
        tick();
        checks++; if (start_out !== 1'b0) begin errors++; $display("FAIL no_retrig1: got %0h exp 0", start_out); end
    endtask

    task automatic test_evolve_stage2();
        base_sprite_in = 8'hFF;
        strobe(8'd200, 10);
        for (int i = 0; i < 40 && start_out != 1'b1; i++) tick();
        checks++; if (start_out !== 1'b1) begin errors++; $display("FAIL start_s2: got %0h exp 1", start_out); end
        checks++; if (level_out !== 7'd36) begin errors++; $display("FAIL lvl_36: got %0d exp 36", level_out); end
        checks++; if (sprite_out !== 8'h00) begin errors++; $display("FAIL sprite_wrap_idle: got %0h exp 0", sprite_out); end
        tick();
        strobe(8'd60, 2);
        checks++; if (level_out !== 7'd36) begin errors++; $display("FAIL lvl_frozen: got %0d exp 36", level_out); end
        checks++; if (dut.xp_bank !== 16'd120) begin errors++; $display("FAIL bank_req: got %0d exp 120", dut.xp_bank); end
        checks++; if (start_out !== 1'b1) begin errors++; $display("FAIL req_hold: got %0h exp 1", start_out); end
`ifdef EVOLVE_CANCEL_EN
        cancel_in = 1'b1;
        tick();
        cancel_in = 1'b0;
        checks++; if (cancelled_out !== 1'b1) begin errors++; $display("FAIL cancel_pulse: got %0h exp 1", cancelled_out); end
        checks++; if (start_out !== 1'b0) begin errors++; $display("FAIL cancel_start: got %0h exp 0", start_out); end
        checks++; if (stage_out !== 2'd1) begin errors++; $display("FAIL cancel_stage: got %0d exp 1", stage_out); end
        tick();
        checks++; if (cancelled_out !== 1'b0) begin errors++; $display("FAIL cancel_one: got %0h exp 0", cancelled_out); end
        tick();
        checks++; if (start_out !== 1'b0) begin errors++; $display("FAIL declined_start: got %0h exp 0", start_out); end
        checks++; if (level_out !== 7'd37) begin errors++; $display("FAIL declined_lvl: got %0d exp 37", level_out); end
        tick();
        checks++; if (start_out !== 1'b1) begin errors++; $display("FAIL rearm: got %0h exp 1", start_out); end
        tick();
        done_in = 1'b1; cancel_in = 1'b1;
        tick();
        done_in = 1'b0; cancel_in = 1'b0;
        checks++; if (cancelled_out !== 1'b0) begin errors++; $display("FAIL both_cancel: got %0h exp 0", cancelled_out); end
`else
        cancel_in = 1'b1;
        tick();
        cancel_in = 1'b0;
        checks++; if (start_out !== 1'b1) begin errors++; $display("FAIL cancel_ign_start: got %0h exp 1", start_out); end
        checks++; if (cancelled_out !== 1'b0) begin errors++; $display("FAIL cancel_ign_pulse: got %0h exp 0", cancelled_out); end
        done_in = 1'b1;
        tick();
        done_in = 1'b0;
`endif
        checks++; if (evolved_out !== 1'b1) begin errors++; $display("FAIL evolved2: got %0h exp 1", evolved_out); end
        checks++; if (stage_out !== 2'd2) begin errors++; $display("FAIL stage2: got %0d exp 2", stage_out); end
        checks++; if (sprite_out !== 8'h01) begin errors++; $display("FAIL sprite_wrap: got %0h exp 01", sprite_out); end
        tick();
        strobe(8'd200, 1);
        for (int i = 0; i < 5; i++) begin
            checks++; if (start_out !== 1'b0) begin errors++; $display("FAIL stage2_retrig: got %0h exp 0", start_out); end
            tick();
        end
        checks++; if (level_out !== 7'd39) begin errors++; $display("FAIL lvl_39: got %0d exp 39", level_out); end
        checks++; if (dut.xp_bank !== 16'd20) begin errors++; $display("FAIL bank_20: got %0d exp 20", dut.xp_bank); end
    endtask

    task automatic test_saturation();
        strobe(8'd100, 61);
        for (int i = 0; i < 10 && level_out != 7'd100; i++) tick();
        tick();
        checks++; if (level_out !== 7'd100) begin errors++; $display("FAIL lvl_max: got %0d exp 100", level_out); end
        checks++; if (dut.xp_bank !== 16'd20) begin errors++; $display("FAIL bank_max: got %0d exp 20", dut.xp_bank); end
        strobe(8'd255, 256);
        strobe(8'd200, 1);
        checks++; if (dut.xp_bank !== 16'd65500) begin errors++; $display("FAIL bank_65500: got %0d exp 65500", dut.xp_bank); end
        strobe(8'd100, 1);
        checks++; if (dut.xp_bank !== 16'hFFFF) begin errors++; $display("FAIL bank_sat: got %0d exp 65535", dut.xp_bank); end
        strobe(8'd255, 1);
        checks++; if (dut.xp_bank !== 16'hFFFF) begin errors++; $display("FAIL bank_sat_hold: got %0d exp 65535", dut.xp_bank); end
        checks++; if (level_out !== 7'd100) begin errors++; $display("FAIL lvl_ceiling: got %0d exp 100", level_out); end
    endtask

    task automatic test_reset_mid();
        rst_n_in = 1'b0;
        tick();
        rst_n_in = 1'b1; base_sprite_in = 8'h10;
        tick();
        strobe(8'd100, 15);
        for (int i = 0; i < 30 && start_out != 1'b1; i++) tick();
        tick();
        checks++; if (start_out !== 1'b1) begin errors++; $display("FAIL mid_req: got %0h exp 1", start_out); end
        #3;
        rst_n_in = 1'b0;
        #1;
        checks++; if (start_out !== 1'b0) begin errors++; $display("FAIL mid_start: got %0h exp 0", start_out); end
        checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL mid_busy: got %0h exp 0", busy_out); end
        checks++; if (level_out !== 7'd1) begin errors++; $display("FAIL mid_level: got %0d exp 1", level_out); end
        checks++; if (stage_out !== 2'd0) begin errors++; $display("FAIL mid_stage: got %0d exp 0", stage_out); end
        checks++; if (sprite_out !== 8'h00) begin errors++; $display("FAIL mid_sprite: got %0h exp 0", sprite_out); end
    endtask

    initial begin
        test_reset();
        test_level_up();
        test_evolve_stage1();
        test_evolve_stage2();
        test_saturation();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/evolve_ctrl.md
# evolve_ctrl

Evolution initiator that drives the `start`/`done` handshake of the on-screen evolution animation block. It accumulates experience, levels the creature up, and decides when an evolution is due. It holds `start_out` while the animation runs and commits the new evolution stage (and sprite index) when the animation reports `done`. It sits between battle/XP logic and the evolution animation/sprite renderer.

## Interface
Parameters:
- `LEVEL_XP`, 100 — XP consumed per level-up (1..255)
- `EVOLVE_LVL1`, 16 — level at which stage 0→1 becomes due
- `EVOLVE_LVL2`, 36 — level at which stage 1→2 becomes due
- `MAX_LEVEL`, 100 — level ceiling (≤127)

Ports:
- `clk_in` in 1 — system/pixel clock
- `rst_n_in` in 1 — asynchronous, active-low reset
- `xp_valid_in` in 1 — one-cycle strobe: add `xp_in` to the XP bank
- `xp_in` in 8 — XP amount
- `base_sprite_in` in 8 — sprite index of stage-0 form
- `done_in` in 1 — completion from the animation block
- `cancel_in` in 1 — player abort request (see Configuration)
- `start_out` out 1 — animation request, level-held
- `sprite_out` out 8 — current sprite index
- `level_out` out 7 — current level
- `stage_out` out 2 — evolution stage 0..2
- `busy_out` out 1 — high whenever FSM ≠ IDLE
- `evolved_out` out 1 — one-cycle pulse on stage commit
- `cancelled_out` out 1 — one-cycle pulse on abort

## Operation
- XP bank: 16-bit, saturates at 65535. `xp_valid_in` is accepted in every state.
- Level-up engine runs only in IDLE. Each cycle with bank ≥ `LEVEL_XP` and level < `MAX_LEVEL`: bank −= `LEVEL_XP`, level += 1. This gives at most one level per cycle.
- Simultaneous add and level-up in the same cycle: bank ← sat(bank + xp_in − LEVEL_XP).
- At `MAX_LEVEL` the bank keeps accumulating (saturating) but never drains.
- `declined` flag: set on abort. It is cleared by the next level-up. While set, evolution does not trigger.
- FSM states:
  - IDLE: evolution is due when (stage=0 and level ≥ EVOLVE_LVL1) or (stage=1 and level ≥ EVOLVE_LVL2), and `declined`=0. When due → ARM. Trigger check has priority over level-up in the same cycle.
  - ARM: `start_out`=1. Waits for `done_in`=0, to flush a stale `done` left from a prior run. On `done_in`=0 → REQ.
  - REQ: `start_out`=1. On `done_in`=1 → COMMIT. Else on `cancel_in`=1 → ABORT. `done_in` wins over `cancel_in` in the same cycle.
  - COMMIT: stage += 1; `sprite_out` ← `base_sprite_in` + new stage (8-bit wrap); `evolved_out`=1; `start_out`=0 → IDLE.
  - ABORT: `declined` ← 1; `cancelled_out`=1; `start_out`=0 → IDLE.
- Stage saturates at 2; stage 2 never triggers.
- `sprite_out` tracks `base_sprite_in` + stage continuously in IDLE (registered).

## Timing
- Reset values: `start_out`=0, `sprite_out`=0, `level_out`=1, `stage_out`=0, `busy_out`=0, `evolved_out`=0, `cancelled_out`=0. XP bank=0, `declined`=0, FSM=IDLE.
- All outputs are registered.
- Trigger: level crossing visible at cycle N → ARM entered and `start_out`=1 at N+1.
- `done_in` high sampled in REQ at cycle M → `evolved_out`, `stage_out`, and `sprite_out` updated at M+1. `start_out` low at M+1.
- Minimum `start_out` high time is 2 cycles (ARM + REQ).
- Reset asserted mid-operation clears every output immediately, with no handshake completion.
- `done_in` outside ARM/REQ is ignored.

## Configuration
- `EVOLVE_CANCEL_EN`:
  - Defined: `cancel_in` is honoured in REQ as described.
  - Undefined: `cancel_in` is ignored, ABORT is unreachable, and `cancelled_out` is tied 0. `declined` is constant 0.

## Test plan
- Reset, then `xp_in`=200 strobe once → level 1→2→3 on consecutive cycles, bank=0, `busy_out`=0.
- 15×`LEVEL_XP` XP from level 1 → level 16, `start_out`=1 next cycle. With `done_in` held 1 at entry: stays in ARM until `done_in`=0. Then `done_in` pulse → `stage_out`=1, `sprite_out`=base+1, `evolved_out` one cycle.
- Reach level 36 at stage 1 with `base_sprite_in`=0xFF → commit `stage_out`=2, `sprite_out`=0x01 (wrap). Further levels → no new `start_out`.
- (`EVOLVE_CANCEL_EN`) `cancel_in`=1 in REQ → `cancelled_out` pulse, stage unchanged, no retrigger. Next level-up → `start_out` reasserts. `cancel_in` and `done_in` same cycle → commit, no cancel pulse.
- Bank at 65500, add 100 → 65535. XP strobes during REQ accumulate, but level is frozen until IDLE.
- `rst_n_in` low while in REQ → `start_out`=0 and all outputs at reset values without a clock edge.
